// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling from a programmable
// bit period, held-valid/ack output register, framing-error and overrun pulses.
module uart_receiver #(
  parameter int CLK_DIV  = 5208,
  parameter int HALF_DIV = CLK_DIV / 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       uart_in,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    // A consumer ack retires the held byte; a delivery below may override this.
    if (data_valid_q && data_ack) begin
      data_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          cnt_d     = BIT_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          state_d = S_IDLE;
          // Same-cycle ack frees the holding register, so the new byte is not lost.
          if (!data_valid_q || data_ack) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= uart_in;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at CLK_DIV=16: expected bytes are queued when a
// frame is driven and popped by a monitor whenever the DUT presents a new byte.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_in;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int rise_cyc = 0;
  logic [7:0] dq[$];

  uart_receiver #(.CLK_DIV(16)) dut (
    .clk_in    (clk),
    .reset     (reset),
    .uart_in   (uart_in),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h ok", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: pulse counters and scoreboard pops on each newly presented byte.
  initial begin
    logic       prev_valid;
    logic [7:0] prev_data;
    logic [7:0] expb;
    prev_valid = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (data_valid && (!prev_valid || data_out != prev_data)) begin
          if (!prev_valid) rise_cyc = cyc;
          if (dq.size() == 0) begin
            chk("sb_pending", dq.size(), 1);
          end else begin
            expb = dq.pop_front();
            chk("rx_byte", data_out, expb);
          end
        end
      end
      prev_valid = data_valid;
      prev_data  = data_out;
    end
  end

  // Drives nbits of the frame {stop, byte, start}, alternating bit periods p_even/p_odd.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int p_even, input int p_odd, input int nbits);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      uart_in = fr[k];
      repeat ((k % 2 == 0) ? p_even : p_odd) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    int n;
    n = 0;
    while (!data_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!data_valid) chk("wait_valid", data_valid, 1);
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    chk("ack_clr", data_valid, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"},  data_out, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_ferr"},  frame_err, 0);
    chk({tag, "_ovr"},   overrun, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  initial begin
    int start_cyc;
    int lat;
    int fe0;
    int ov0;
    logic [7:0] tol_b[4]  = '{8'h55, 8'h55, 8'hFF, 8'hFF};
    int         tol_pe[4] = '{15, 17, 15, 17};
    int         tol_po[4] = '{17, 15, 15, 17};

    reset    = 1'b1;
    uart_in  = 1'b1;
    data_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Nominal frame and first-byte latency
    dq.push_back(8'hA5);
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 16, 16, 10);
    wait_valid(400);
    lat = rise_cyc - start_cyc;
    $display("latency %0d cycles", lat);
    chk("latency_in_range", (lat >= 153 && lat <= 155), 1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_no_ferr", fe_cnt, 0);
    do_ack();

    // Short low glitch
    uart_in = 1'b0;
    repeat (4) @(negedge clk);
    uart_in = 1'b1;
    chk("glitch_busy_hi", busy, 1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_no_valid", data_valid, 0);
    chk("glitch_no_ferr", fe_cnt, 0);

    // Bad stop bit followed by a held-low line
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 16, 16, 10);
    repeat (100) @(negedge clk);
    uart_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_one_ferr", fe_cnt - fe0, 1);
    chk("break_no_valid", data_valid, 0);
    dq.push_back(8'h81);
    send_frame(8'h81, 1'b1, 16, 16, 10);
    wait_valid(400);
    chk("after_break_data", data_out, 8'h81);
    do_ack();

    // Back-to-back without ack: second byte overruns
    ov0 = ov_cnt;
    dq.push_back(8'h11);
    send_frame(8'h11, 1'b1, 16, 16, 10);
    send_frame(8'h22, 1'b1, 16, 16, 10);
    repeat (20) @(negedge clk);
    chk("ovr_pulse", ov_cnt - ov0, 1);
    chk("ovr_kept", data_out, 8'h11);
    chk("ovr_valid", data_valid, 1);
    do_ack();

    // Back-to-back with ack on the second stop-sample cycle
    ov0 = ov_cnt;
    dq.push_back(8'h11);
    dq.push_back(8'h22);
    fork
      begin
        send_frame(8'h11, 1'b1, 16, 16, 10);
        send_frame(8'h22, 1'b1, 16, 16, 10);
      end
      begin
        repeat (314) @(posedge clk);
        @(negedge clk);
        data_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_ack = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("ack_no_ovr", ov_cnt - ov0, 0);
    chk("ack_new_data", data_out, 8'h22);
    do_ack();

    // Bit-period deviation
    fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) begin
      uart_in = 1'b1;
      repeat (20) @(negedge clk);
      dq.push_back(tol_b[i]);
      send_frame(tol_b[i], 1'b1, tol_pe[i], tol_po[i], 10);
      wait_valid(400);
      chk("tol_data", data_out, tol_b[i]);
      do_ack();
    end
    chk("tol_no_ferr", fe_cnt - fe0, 0);

    // Reset in the middle of a frame
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h5A, 1'b1, 16, 16, 5);
    uart_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midrst");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_valid", data_valid, 0);
    chk("midrst_no_ferr", fe_cnt - fe0, 0);
    dq.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 16, 16, 10);
    wait_valid(400);
    chk("midrst_c3", data_out, 8'hC3);
    do_ack();
    chk("midrst_no_ovr", ov_cnt - ov0, 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
